// File: rtl/c_requant_writer_pkg.sv
// Shared constants, state encoding and the requantisation arithmetic for the
// C-result writer that sits behind the 16x49 x 49x32 matrix multiplier.
package c_requant_writer_pkg;

    localparam int NUM_WORDS = 512;
    localparam int NUM_COLS  = 32;
    localparam int C_W       = 32;
    localparam int OUT_W     = 16;
    localparam int BIAS_W    = 16;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_BIAS = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Round-half-up arithmetic shift of a 33-bit sum in 34-bit headroom,
    // then saturate to int16 and optionally clamp negatives to zero.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [C_W:0] sum,
        input logic        [4:0]   shift,
        input logic                relu
    );
        logic signed [C_W+1:0]  r;
        logic signed [OUT_W-1:0] res;
        r = {sum[C_W], sum};
        if (shift != 5'd0) begin
            r = (r + (34'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        if (r > 34'sd32767) begin
            res = 16'sh7fff;
        end else if (r < -34'sd32768) begin
            res = 16'sh8000;
        end else begin
            res = r[OUT_W-1:0];
        end
        if (relu && res[OUT_W-1]) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push while full is accepted
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/c_requant_writer.sv
// Captures the multiplier's C write stream, adds per-column bias, requantises
// to int16 and streams results to the activation buffer.
module c_requant_writer
    import c_requant_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    output logic [4:0]        bias_addr,
    input  logic [BIAS_W-1:0] bias_data,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [C_W-1:0]    in_data,
    input  logic              in_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]  out_data,
    output logic              done,
    output logic              overflow_err,
    output logic              count_err
);

    state_t state;
    state_t state_next;

    logic [5:0]               load_cnt;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic                     done_seen;
    logic [9:0]               out_count;
    logic signed [BIAS_W-1:0] bias_rf [NUM_COLS];

    logic [ADDR_W+C_W-1:0]    fifo_rdata;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [C_W-1:0]           fifo_c;
    logic [ADDR_W-1:0]        fifo_a;
    logic [BIAS_W-1:0]        bias_sel;

    logic                     s1_valid;
    logic [ADDR_W-1:0]        s1_addr;
    logic signed [C_W:0]      s1_sum;
    logic                     stall;
    logic                     drain_done;

    assign stall      = out_valid && !out_ready;
    assign fifo_push  = in_we && (state == LOAD_BIAS || state == RUN);
    assign fifo_pop   = (state == RUN) && !fifo_empty && !stall;
    assign fifo_c     = fifo_rdata[C_W-1:0];
    assign fifo_a     = fifo_rdata[ADDR_W+C_W-1:C_W];
    assign bias_sel   = bias_rf[fifo_a[4:0]];
    assign drain_done = done_seen && fifo_empty && !s1_valid && !out_valid;

    sync_fifo #(
        .WIDTH (ADDR_W + C_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({in_addr, in_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        bias_addr  = 5'd0;
        done       = 1'b0;
        case (state)
            IDLE:      if (start) state_next = LOAD_BIAS;
            LOAD_BIAS: begin
                bias_addr = load_cnt[4:0];
                if (load_cnt == 6'd32) state_next = RUN;
            end
            RUN:       if (drain_done) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Control registers; a start in IDLE re-arms everything for a new matrix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt     <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            done_seen    <= 1'b0;
            overflow_err <= 1'b0;
            count_err    <= 1'b0;
            out_count    <= '0;
        end else if (state == IDLE && start) begin
            load_cnt     <= '0;
            shift_q      <= shift;
            relu_q       <= relu_en;
            done_seen    <= 1'b0;
            overflow_err <= 1'b0;
            count_err    <= 1'b0;
            out_count    <= '0;
        end else begin
            if (state == LOAD_BIAS) load_cnt <= load_cnt + 6'd1;
            if (in_done && (state == LOAD_BIAS || state == RUN)) done_seen <= 1'b1;
            if (fifo_push && fifo_full && !fifo_pop) overflow_err <= 1'b1;
            if (out_valid && out_ready) out_count <= out_count + 10'd1;
            if (state == RUN && drain_done) count_err <= (out_count != 10'(NUM_WORDS));
        end
    end

    // ROM data lags its address by one cycle, so capture entry k-1 at count k.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) bias_rf[i] <= '0;
        end else if (state == LOAD_BIAS && load_cnt != 6'd0) begin
            bias_rf[load_cnt[4:0] - 5'd1] <= bias_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_sum    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (!stall) begin
            s1_valid  <= fifo_pop;
            if (fifo_pop) begin
                s1_addr <= fifo_a;
                s1_sum  <= {fifo_c[C_W-1], fifo_c} + {{(C_W-BIAS_W+1){bias_sel[BIAS_W-1]}}, bias_sel};
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_addr <= s1_addr;
                out_data <= requant(s1_sum, shift_q, relu_q);
            end
        end
    end

endmodule

// File: tb/tb_c_requant_writer.sv
// Directed bench for c_requant_writer: expected words queue up as stimulus is
// driven and are checked against each accepted output beat.
module tb_c_requant_writer;

    typedef logic signed [63:0] val_t;
    typedef struct {
        logic [8:0] addr;
        longint     data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  shift;
    logic        relu_en;
    logic [4:0]  bias_addr;
    logic [15:0] bias_data;
    logic        in_we;
    logic [8:0]  in_addr;
    logic [31:0] in_data;
    logic        in_done;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_addr;
    logic [15:0] out_data;
    logic        done;
    logic        overflow_err;
    logic        count_err;

    exp_t              sb[$];
    logic signed [15:0] rom [32];
    int                n_cmp = 0;
    int                n_fail = 0;
    int                done_count = 0;
    int                n_out = 0;
    int                cur_shift = 0;
    bit                cur_relu = 1'b0;

    c_requant_writer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .shift        (shift),
        .relu_en      (relu_en),
        .bias_addr    (bias_addr),
        .bias_data    (bias_data),
        .in_we        (in_we),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_done      (in_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .done         (done),
        .overflow_err (overflow_err),
        .count_err    (count_err)
    );

    always #5 clk = ~clk;

    // Synchronous bias ROM model: data follows the address by one cycle.
    always @(posedge clk) bias_data <= rom[bias_addr];

    task automatic check_output(input string tag, input val_t obs, input val_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Floor-division formulation of round-half-up shift, saturation and ReLU.
    function automatic longint model(longint c, longint b, int sh, bit relu);
        longint s, d, n, q;
        s = c + b;
        if (sh == 0) begin
            q = s;
        end else begin
            d = longint'(1) << sh;
            n = s + d / 2;
            q = n / d;
            if (n % d != 0 && n < 0) q = q - 1;
        end
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [8:0] addr, input logic [31:0] data, input bit keep);
        in_we   = 1'b1;
        in_addr = addr;
        in_data = data;
        if (keep) sb.push_back('{addr: addr, data: model($signed(data), rom[addr[4:0]], cur_shift, cur_relu)});
        tick();
        in_we = 1'b0;
    endtask

    task automatic start_matrix(input int sh, input bit relu, input bit check_addr);
        cur_shift = sh;
        cur_relu  = relu;
        shift     = 5'(sh);
        relu_en   = relu;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (check_addr) check_output("bias_addr_step", bias_addr, k);
            tick();
        end
        tick();
        tick();
    endtask

    task automatic finish_matrix(input bit exp_err);
        int d0;
        d0 = done_count;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        for (int i = 0; i < 300 && done_count == d0; i++) tick();
        repeat (4) tick();
        check_output("done_pulses", done_count - d0, 1);
        check_output("count_err", count_err, exp_err);
        check_output("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) done_count++;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            check_output("out_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("out_addr", out_addr, e.addr);
                check_output("out_data", $signed(out_data), e.data);
            end
        end
    end

    initial begin
        int d0;
        int n0;
        reset     = 1'b1;
        start     = 1'b0;
        shift     = '0;
        relu_en   = 1'b0;
        in_we     = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_done   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) rom[k] = 16'(k - 16);
        tick();
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_data", out_data, 0);
        check_output("rst_out_addr", out_addr, 0);
        check_output("rst_done", done, 0);
        check_output("rst_overflow", overflow_err, 0);
        check_output("rst_count_err", count_err, 0);
        check_output("rst_bias_addr", bias_addr, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] bias load with bias[k]=k-16");
        start_matrix(0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) apply_stimulus(9'(k), 32'd0, 1'b1);
        finish_matrix(1'b1);

        $display("[TB] basic requant and latency");
        for (int k = 0; k < 32; k++) rom[k] = 16'sd0;
        rom[3] = 16'sd8;
        start_matrix(4, 1'b0, 1'b0);
        apply_stimulus(9'd3, 32'd100, 1'b1);
        check_output("lat_edge1", out_valid, 0);
        tick();
        check_output("lat_edge2", out_valid, 0);
        tick();
        check_output("lat_edge3", out_valid, 1);
        check_output("basic_addr", out_addr, 3);
        check_output("basic_data", $signed(out_data), 7);
        finish_matrix(1'b1);

        $display("[TB] saturation and relu");
        start_matrix(0, 1'b0, 1'b0);
        apply_stimulus(9'd0, 32'sd40000, 1'b1);
        apply_stimulus(9'd1, -32'sd40000, 1'b1);
        finish_matrix(1'b1);
        start_matrix(0, 1'b1, 1'b0);
        apply_stimulus(9'd0, -32'sd40000, 1'b1);
        apply_stimulus(9'd1, 32'sd40000, 1'b1);
        finish_matrix(1'b1);

        $display("[TB] negative rounding");
        start_matrix(2, 1'b0, 1'b0);
        apply_stimulus(9'd0, -32'sd6, 1'b1);
        apply_stimulus(9'd1, -32'sd7, 1'b1);
        finish_matrix(1'b1);

        $display("[TB] backpressure and overflow");
        start_matrix(0, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(9'(i + 8), 32'(i * 1000 - 3000), i < 6);
            if (i == 5) check_output("no_overflow_yet", overflow_err, 0);
        end
        check_output("overflow_set", overflow_err, 1);
        repeat (3) tick();
        check_output("stall_valid", out_valid, 1);
        check_output("stall_addr", out_addr, 8);
        check_output("stall_data", $signed(out_data), -3000);
        out_ready = 1'b1;
        repeat (12) tick();
        finish_matrix(1'b1);

        $display("[TB] full matrix with random ready");
        for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
        start_matrix(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0);
        n0 = n_out;
        for (int c = 0; c < 512 * 6; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (c % 6 == 0) apply_stimulus(9'(c / 6), $urandom, 1'b1);
            else            tick();
        end
        out_ready = 1'b1;
        finish_matrix(1'b0);
        check_output("full_out_count", n_out - n0, 512);
        check_output("full_no_overflow", overflow_err, 0);

        $display("[TB] reset mid-matrix");
        start_matrix(3, 1'b0, 1'b0);
        for (int w = 0; w < 200; w++) begin
            apply_stimulus(9'(w), $urandom, 1'b1);
            repeat (5) tick();
        end
        reset = 1'b1;
        #1;
        check_output("abort_out_valid", out_valid, 0);
        check_output("abort_out_data", out_data, 0);
        check_output("abort_out_addr", out_addr, 0);
        check_output("abort_overflow", overflow_err, 0);
        check_output("abort_count_err", count_err, 0);
        sb.delete();
        d0 = done_count;
        repeat (3) tick();
        reset = 1'b0;
        repeat (100) tick();
        check_output("abort_no_done", done_count - d0, 0);

        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        repeat (20) tick();
        check_output("idle_in_done_ignored", done_count - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
